// File: rtl/main_fsm.sv
// main_fsm: multicycle processor control unit (Moore FSM).
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   reset      - synchronous, active-high reset (forces FETCH)
//   Op         - instruction class: 00 data-proc, 01 memory, 10 branch, 11 undefined
//   Funct      - Funct[5] = I (immediate), Funct[0] = L (load/store select)
//   MemReady   - memory access completes this cycle
//   IRWrite    - instruction register load enable
//   AdrSrc     - memory address select (0 PC, 1 ALU result)
//   ALUSrcA    - ALU A select (00 register, 01 PC)
//   ALUSrcB    - ALU B select (00 register, 01 immediate, 10 constant 4)
//   ResultSrc  - result select (00 ALU out reg, 01 read data, 10 ALU result)
//   NextPC     - PC update enable
//   RegW       - register write request
//   MemW       - memory write request
//   Branch     - branch request
//   ALUOp      - 1 = ALU decoder decodes Funct, 0 = force ADD
//   State      - current state code (debug)
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t state, state_next;

  // Only the I and L bits of Funct steer the sequence.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:    state_next = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b00:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_next = MemReady ? MEMWB : MEMRD;
      MEMWB:    state_next = FETCH;
      MEMWR:    state_next = MemReady ? FETCH : MEMWR;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      default:  state_next = FETCH;
    endcase
  end

  // Write/update strobes are masked by reset so nothing commits while
  // reset is held, even when the register still shows a non-FETCH state.
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = MemReady & ~reset;
        NextPC    = MemReady & ~reset;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = ~reset;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = ~reset;
      end
      EXECUTER: begin
        ALUOp = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        RegW = ~reset;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = ~reset;
      end
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: the stimulus process pushes, per cycle,
// the hand-derived state and output word; the monitor pops and compares
// on the falling edge.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;

  main_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                         MW = 4'd5, EXR = 4'd6, EXI = 4'd7, AWB = 4'd8, BR = 4'd9;

  typedef struct packed {
    logic [3:0]  st;
    logic [12:0] o;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Output word {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ALUOp}
  function automatic logic [12:0] exp_out(input logic [3:0] st, input logic mr, input logic rst);
    logic irw, adr, npc, rw, mw, br, aop;
    logic [1:0] a, b, r;
    irw = 0; adr = 0; npc = 0; rw = 0; mw = 0; br = 0; aop = 0;
    a = 2'b00; b = 2'b00; r = 2'b00;
    case (st)
      F:   begin irw = mr & ~rst; npc = mr & ~rst; a = 2'b01; b = 2'b10; r = 2'b10; end
      D:   begin a = 2'b01; b = 2'b10; r = 2'b10; end
      MA:  begin b = 2'b01; end
      MR:  begin adr = 1; end
      MWB: begin r = 2'b01; rw = ~rst; end
      MW:  begin adr = 1; mw = ~rst; end
      EXR: begin aop = 1; end
      EXI: begin b = 2'b01; aop = 1; end
      AWB: begin rw = ~rst; end
      BR:  begin b = 2'b01; r = 2'b10; br = ~rst; end
      default: ;
    endcase
    return {irw, adr, a, b, r, npc, rw, mw, br, aop};
  endfunction

  task automatic step(input logic r, input logic [1:0] op, input logic [5:0] f,
                      input logic mr, input logic [3:0] es);
    @(posedge clk);
    #1;
    reset = r; Op = op; Funct = f; MemReady = mr;
    q.push_back('{st: es, o: exp_out(es, mr, r)});
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    logic [12:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      cyc++;
      act = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp};
      checks++;
      if (State !== e.st) begin
        errors++;
        $display("FAIL state cyc=%0d actual=%0d required=%0d", cyc, State, e.st);
      end
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL outputs cyc=%0d state=%0d actual=%b required=%b", cyc, e.st, act, e.o);
      end
    end
  end

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = '0; MemReady = 1'b0;
    // reset held with MemReady=1: strobes stay low
    step(1, 0, 0, 1, F);
    step(1, 0, 0, 1, F);
    // data-processing, register operand
    step(0, 0, 6'h00, 1, F);
    step(0, 0, 6'h00, 1, D);
    step(0, 3, 6'h3f, 1, EXR);
    step(0, 0, 6'h00, 1, AWB);
    // data-processing, immediate
    step(0, 0, 6'h00, 1, F);
    step(0, 0, 6'h20, 1, D);
    step(0, 0, 6'h00, 1, EXI);
    step(0, 0, 6'h00, 1, AWB);
    // load with three wait cycles, Op changing while waiting
    step(0, 0, 6'h00, 1, F);
    step(0, 1, 6'h01, 1, D);
    step(0, 1, 6'h01, 0, MA);
    step(0, 2, 6'h00, 0, MR);
    step(0, 2, 6'h00, 0, MR);
    step(0, 2, 6'h00, 0, MR);
    step(0, 0, 6'h00, 1, MR);
    step(0, 0, 6'h00, 1, MWB);
    // store
    step(0, 0, 6'h00, 1, F);
    step(0, 1, 6'h00, 1, D);
    step(0, 1, 6'h00, 1, MA);
    step(0, 0, 6'h00, 1, MW);
    // branch
    step(0, 0, 6'h00, 1, F);
    step(0, 2, 6'h00, 1, D);
    step(0, 0, 6'h00, 1, BR);
    // undefined
    step(0, 0, 6'h00, 1, F);
    step(0, 3, 6'h00, 1, D);
    // fetch stall for five cycles
    for (int i = 0; i < 5; i++) step(0, 1, 6'h21, 0, F);
    step(0, 0, 6'h00, 1, F);
    // store stalled, then reset mid-wait
    step(0, 1, 6'h00, 1, D);
    step(0, 1, 6'h00, 1, MA);
    step(0, 0, 6'h00, 0, MW);
    step(0, 0, 6'h00, 0, MW);
    step(1, 0, 6'h00, 0, MW);
    step(0, 0, 6'h00, 0, F);
    step(0, 0, 6'h00, 1, F);
    // load stalled, then reset mid-wait
    step(0, 1, 6'h01, 1, D);
    step(0, 1, 6'h01, 1, MA);
    step(0, 0, 6'h00, 0, MR);
    step(1, 0, 6'h00, 0, MR);
    step(0, 0, 6'h00, 1, F);
    // first fetch after reset proceeds normally
    step(0, 0, 6'h00, 1, D);
    step(0, 0, 6'h00, 1, EXR);
    step(0, 0, 6'h00, 0, AWB);
    step(0, 0, 6'h00, 0, F);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
